pmem_arbiter: RTL
=================

# pmem_arbiter

Shares the single physical-memory port between the instruction cache and the data cache. Sits between the two caches' `pmem_*` miss/writeback interfaces and the cacheline-wide memory (or L2) port. It grants one whole-line transaction at a time and holds the grant until the memory responds. It latches the winner's address and write data, routes the response back, and enforces a one-cycle turnaround between transactions.

## Interface
- `s_line`, 256: cacheline width in bits
- `s_addr`, 32: physical address width
- `clk  in  1`: system clock, all state updates on rising edge
- `rst_n  in  1`: asynchronous, active-low reset
- `i_pmem_read  in  1`: icache line-fill request
- `i_pmem_address  in  s_addr`: icache line address
- `i_pmem_rdata  out  s_line`: fill data to icache
- `i_pmem_resp  out  1`: icache transaction complete
- `d_pmem_read  in  1`: dcache line-fill request
- `d_pmem_write  in  1`: dcache writeback request
- `d_pmem_address  in  s_addr`: dcache line address
- `d_pmem_wdata  in  s_line`: dcache writeback data
- `d_pmem_rdata  out  s_line`: fill data to dcache
- `d_pmem_resp  out  1`: dcache transaction complete
- `mem_read  out  1`: memory read strobe
- `mem_write  out  1`: memory write strobe
- `mem_address  out  s_addr`: latched address of the granted transaction
- `mem_wdata  out  s_line`: latched writeback data
- `mem_rdata  in  s_line`: memory read data
- `mem_resp  in  1`: memory completion pulse

## Operation
- FSM states: `IDLE`, `SERVE_I`, `SERVE_D`, `TURN`.
- `IDLE`: sample the requests.
  - Dcache request only (`d_pmem_read|d_pmem_write`): go to `SERVE_D`.
  - Icache request only: go to `SERVE_I`.
  - Both request: the arbitration policy picks the winner (see Configuration).
  - On the grant edge, capture the winner's address into `mem_address`. For a dcache write, also capture `d_pmem_wdata` into `mem_wdata` and record op=write; otherwise record op=read.
- `SERVE_I` / `SERVE_D`: drive `mem_read` or `mem_write` from the registered op.
  - Requester inputs are ignored while in these states; the latched copies are authoritative.
  - When `mem_resp` is high: assert the owner's `*_pmem_resp` combinationally in the same cycle, drive `mem_rdata` onto the owner's `*_rdata`, and go to `TURN`.
- `TURN`: one cycle with no strobes, then go to `IDLE`. This gives the requester a cycle to drop its request, so a stale request is never regranted.
- `d_pmem_read` and `d_pmem_write` both high is illegal. Write wins, and a simulation-only assertion flags it.
- Non-owner `*_pmem_resp` is always 0. `*_rdata` outputs are `mem_rdata` when owned, 0 otherwise.

## Timing
- Reset values (async, immediate): state=`IDLE`, `mem_read`=0, `mem_write`=0, `mem_address`=0, `mem_wdata`=0, `i_pmem_resp`=0, `d_pmem_resp`=0, rr_last=icache.
- Request high in `IDLE` at edge N: strobe high from N+1.
- `mem_resp` at cycle M: owner resp at M (zero latency), strobe low from M+1, `IDLE` at M+2.
- Earliest next grant is edge M+2; the next strobe is at M+3.
- Minimum transaction: 4 cycles, from request to the next possible strobe with a 1-cycle memory.
- `mem_resp` outside `SERVE_*` is ignored.
- Reset asserted mid-transaction:
  - Strobes drop asynchronously and the transaction is abandoned with no resp to either cache.
  - A pending `mem_resp` after reset is ignored.
- Requester drops its request mid-serve: the transaction still completes and resp is still pulsed.

## Configuration
- `PMEM_ARB_RR_EN` defined:
  - Round-robin on contention. A 1-bit `rr_last` register records the last-served side; on simultaneous requests the other side wins.
  - `rr_last` updates on every grant.
- Undefined:
  - Fixed priority, dcache always wins on contention. `rr_last` is not instantiated.
  - Icache can starve only under continuous dcache traffic, which is acceptable given the `TURN` gap.

## Structure
- The `pmem_arb_state_t` enum (`IDLE`, `SERVE_I`, `SERVE_D`, `TURN`) and the `pmem_op_t` enum (read/write) go in `rv32i_types`.
- One sub-module, `pmem_arb_select`: pure grant logic.
  - Inputs: requests and `rr_last`.
  - Outputs: grant_i, grant_d, op.
- FSM, latches and routing live in `pmem_arbiter`.

## Test plan
- Reset with strobes forced high mid-serve, then `rst_n`=0 → `mem_read`/`mem_write` drop the same cycle, state=`IDLE`, no resp pulses.
- Icache read only, addr 0x0000_1000, `mem_resp` after 3 cycles with rdata=0xAA..AA → `mem_address`=0x1000, `mem_read` high for 3 cycles, `i_pmem_resp` one cycle with rdata 0xAA..AA, `d_pmem_resp`=0.
- Dcache write, addr 0x8000_0020, wdata 0x5555.., address changed to 0xDEAD_0000 one cycle after grant → `mem_write` high, `mem_address` stays 0x8000_0020, `mem_wdata`=0x5555.., `d_pmem_resp` pulses once.
- Simultaneous i/d read, both held across 3 transactions:
  - Without `PMEM_ARB_RR_EN`: order is D, D, D.
  - With it: order is D, I, D.
  - In both cases, strobes are never high in the `TURN` cycle.
- Back-to-back dcache read then icache read, 1-cycle `mem_resp` → exactly one idle cycle between strobes, second grant at M+2.
- `d_pmem_read`=`d_pmem_write`=1 → write issued, assertion fires, `d_pmem_resp` pulses once.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the physical-memory arbiter: FSM states, op encoding and
// round-robin side encoding.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        TURN
    } pmem_arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } pmem_op_t;

    localparam logic RR_ICACHE = 1'b0;
    localparam logic RR_DCACHE = 1'b1;

endpackage

// File: rtl/pmem_arb_select.sv
// Pure grant logic for the pmem arbiter: picks icache or dcache and the op.
// With PMEM_ARB_RR_EN contention alternates on rr_last; otherwise dcache wins.
module pmem_arb_select
    import rv32i_types::*;
(
    input  logic     i_read,
    input  logic     d_read,
    input  logic     d_write,
`ifdef PMEM_ARB_RR_EN
    input  logic     rr_last,
`endif
    output logic     grant_i,
    output logic     grant_d,
    output pmem_op_t op
);

    logic d_req;

    assign d_req = d_read | d_write;

`ifdef PMEM_ARB_RR_EN
    assign grant_d = d_req & (~i_read | (rr_last == RR_ICACHE));
`else
    assign grant_d = d_req;
`endif
    assign grant_i = i_read & ~grant_d;

    // A simultaneous read+write from dcache resolves to the write.
    assign op = (grant_d && d_write) ? OP_WRITE : OP_READ;

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one cacheline-wide memory port between icache and dcache, one whole
// transaction at a time with a one-cycle turnaround. Define PMEM_ARB_RR_EN for
// round-robin arbitration; default is fixed dcache priority.
module pmem_arbiter
    import rv32i_types::*;
#(
    parameter int s_line = 256,
    parameter int s_addr = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [s_addr-1:0] i_pmem_address,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [s_addr-1:0] d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [s_addr-1:0] mem_address,
    output logic [s_line-1:0] mem_wdata,
    input  logic [s_line-1:0] mem_rdata,
    input  logic              mem_resp
);

    pmem_arb_state_t state;
    pmem_op_t        sel_op;
    logic            grant_i, grant_d;
`ifdef PMEM_ARB_RR_EN
    logic            rr_last;
`endif

    pmem_arb_select u_select (
        .i_read  (i_pmem_read),
        .d_read  (d_pmem_read),
        .d_write (d_pmem_write),
`ifdef PMEM_ARB_RR_EN
        .rr_last (rr_last),
`endif
        .grant_i (grant_i),
        .grant_d (grant_d),
        .op      (sel_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
`ifdef PMEM_ARB_RR_EN
            rr_last     <= RR_ICACHE;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state       <= SERVE_D;
                        mem_address <= d_pmem_address;
                        mem_read    <= (sel_op == OP_READ);
                        mem_write   <= (sel_op == OP_WRITE);
                        if (sel_op == OP_WRITE)
                            mem_wdata <= d_pmem_wdata;
`ifdef PMEM_ARB_RR_EN
                        rr_last     <= RR_DCACHE;
`endif
                    end else if (grant_i) begin
                        state       <= SERVE_I;
                        mem_address <= i_pmem_address;
                        mem_read    <= 1'b1;
                        mem_write   <= 1'b0;
`ifdef PMEM_ARB_RR_EN
                        rr_last     <= RR_ICACHE;
`endif
                    end
                end
                // Requester inputs are ignored here; the latched copies drive memory.
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state     <= TURN;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Completion is routed combinationally so the owner sees resp with zero latency.
    assign i_pmem_resp  = (state == SERVE_I) & mem_resp;
    assign d_pmem_resp  = (state == SERVE_D) & mem_resp;
    assign i_pmem_rdata = (state == SERVE_I) ? mem_rdata : '0;
    assign d_pmem_rdata = (state == SERVE_D) ? mem_rdata : '0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n)
            assert (!(d_pmem_read && d_pmem_write))
            else $warning("pmem_arbiter: d_pmem_read and d_pmem_write both high, write takes precedence");
    end
`endif

endmodule
